prog_counter: RTL and testbench

//  Program counter fed by the statemach prog_state output. Sits downstream of statemach:

---
 rtl/prog_pkg.sv | 34 +++
 rtl/prog_counter.sv | 105 ++++++++++
 tb/tb_prog_counter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/prog_pkg.sv
// Shared types, default parameters and start-address lookup for the program counter.
package prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } pc_state_t;

  localparam int unsigned DEFAULT_PC_W   = 10;
  localparam int unsigned DEFAULT_OFF_W  = 8;
  localparam int unsigned DEFAULT_START1 = 0;
  localparam int unsigned DEFAULT_START2 = 64;
  localparam int unsigned DEFAULT_START3 = 128;

  // Map program select to its start address; select 0 is statemach wrap-around.
  function automatic int unsigned start_addr(
    input logic [1:0]  prog_state,
    input int unsigned s1,
    input int unsigned s2,
    input int unsigned s3
  );
    int unsigned addr;
    case (prog_state)
      2'd1:    addr = s1;
      2'd2:    addr = s2;
      2'd3:    addr = s3;
      default: addr = 0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter: holds during init, restarts at the selected program's start
// address on init fall, then steps/branches/stalls until halt.
module prog_counter
  import prog_pkg::*;
#(
  parameter int unsigned PC_W   = DEFAULT_PC_W,
  parameter int unsigned OFF_W  = DEFAULT_OFF_W,
  parameter int unsigned START1 = DEFAULT_START1,
  parameter int unsigned START2 = DEFAULT_START2,
  parameter int unsigned START3 = DEFAULT_START3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic [1:0]        i_prog_state,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [OFF_W-1:0]  i_branch_offset,
  input  logic              i_halt,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_running,
  output logic              o_done,
  output logic [1:0]        o_prog_id
);

  pc_state_t       r_state;
  pc_state_t       w_state_nxt;
  logic            r_init_q;
  logic            w_fall;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_off_ext;
  logic [1:0]      r_prog_id;
  logic [1:0]      w_prog_id_nxt;

  assign w_fall    = r_init_q & ~i_init;
  assign w_off_ext = PC_W'($signed(i_branch_offset));

  // State, pc, program id and init history registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_prog_id <= '0;
      r_init_q  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_prog_id <= w_prog_id_nxt;
      r_init_q  <= i_init;
    end
  end

  // Next state and next pc; init overrides everything, halt > stall > branch > step in RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_prog_id_nxt = r_prog_id;
    if (i_init) begin
      w_state_nxt = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (w_fall) begin
            w_state_nxt   = ST_RUN;
            w_pc_nxt      = PC_W'(start_addr(i_prog_state, START1, START2, START3));
            w_prog_id_nxt = i_prog_state;
          end
        end
        ST_RUN: begin
          if (i_halt) begin
            w_state_nxt = ST_DONE;
          end else if (i_stall) begin
            w_pc_nxt = r_pc;
          end else if (i_branch_taken) begin
            w_pc_nxt = r_pc + w_off_ext;
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    o_running = 1'b0;
    o_done    = 1'b0;
    case (r_state)
      ST_RUN:  o_running = 1'b1;
      ST_DONE: o_done    = 1'b1;
      default: begin
        o_running = 1'b0;
        o_done    = 1'b0;
      end
    endcase
  end

  assign o_pc      = r_pc;
  assign o_prog_id = r_prog_id;

endmodule

// File: tb/tb_prog_counter.sv
// Directed and randomized check of prog_counter against a behavioural model.
module tb_prog_counter;

  localparam int PC_MOD = 1024;

  logic       clk;
  logic       rst_n;
  logic       init;
  logic [1:0] prog_state;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_offset;
  logic       halt;
  logic [9:0] pc;
  logic       running;
  logic       done;
  logic [1:0] prog_id;

  prog_counter #(
    .PC_W   (10),
    .OFF_W  (8),
    .START1 (0),
    .START2 (64),
    .START3 (1020)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_init          (init),
    .i_prog_state    (prog_state),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .i_halt          (halt),
    .o_pc            (pc),
    .o_running       (running),
    .o_done          (done),
    .o_prog_id       (prog_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Behavioural model: mode is one of "idle", "hold", "run", "done".
  string m_mode;
  int    m_pc;
  int    m_pid;
  bit    m_init_prev;
  int    starts [4];

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int so;
    bit fall;
    if (!rst_n) begin
      m_mode = "idle"; m_pc = 0; m_pid = 0; m_init_prev = 0;
    end else begin
      fall = m_init_prev && !init;
      if (init) begin
        m_mode = "hold";
      end else if (m_mode == "hold" && fall) begin
        m_mode = "run";
        m_pc   = starts[prog_state];
        m_pid  = int'(prog_state);
      end else if (m_mode == "run") begin
        if (halt) m_mode = "done";
        else if (stall) m_pc = m_pc;
        else if (branch_taken) begin
          so   = (branch_offset >= 8'd128) ? int'(branch_offset) - 256 : int'(branch_offset);
          m_pc = ((m_pc + so) % PC_MOD + PC_MOD) % PC_MOD;
        end else m_pc = (m_pc + 1) % PC_MOD;
      end
      m_init_prev = init;
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare #1 later.
  task automatic cyc(input bit r, input bit in, input int ps, input bit st,
                     input bit br, input int off, input bit h);
    @(negedge clk);
    rst_n = r; init = in; prog_state = 2'(ps); stall = st;
    branch_taken = br; branch_offset = 8'(off); halt = h;
    @(posedge clk);
    model_step();
    #1;
    check("pc",      int'(pc),      m_pc);
    check("running", int'(running), (m_mode == "run")  ? 1 : 0);
    check("done",    int'(done),    (m_mode == "done") ? 1 : 0);
    check("prog_id", int'(prog_id), m_pid);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    starts = '{0, 0, 64, 1020};
    m_mode = "idle"; m_pc = 0; m_pid = 0; m_init_prev = 0;
    rst_n = 0; init = 0; prog_state = 0; stall = 0;
    branch_taken = 0; branch_offset = 0; halt = 0;

    // Reset with init/halt toggling
    cyc(0, 1, 1, 0, 0, 0, 1);
    cyc(0, 0, 2, 0, 1, 5, 0);
    check("rst_pc", int'(pc), 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    run_n(2);
    check("idle_pc", int'(pc), 0);

    // Program 1: hold, fall, five steps, halt
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0, 0);
    check("hold_running", int'(running), 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    check("p1_start", int'(pc), 0);
    check("p1_running", int'(running), 1);
    run_n(5);
    check("p1_pc5", int'(pc), 5);
    cyc(1, 0, 1, 0, 0, 0, 1);
    check("p1_done", int'(done), 1);
    run_n(3);
    check("p1_done_hold_pc", int'(pc), 5);
    check("p1_done_held", int'(done), 1);

    // Program 2: branches and stall
    cyc(1, 1, 2, 0, 0, 0, 0);
    check("init_clears_done", int'(done), 0);
    cyc(1, 0, 2, 0, 0, 0, 0);
    check("p2_start", int'(pc), 64);
    check("p2_id", int'(prog_id), 2);
    run_n(6);
    check("p2_pc70", int'(pc), 70);
    cyc(1, 0, 2, 0, 1, -4, 0);
    check("p2_branch_back", int'(pc), 66);
    cyc(1, 0, 2, 1, 1, 10, 0);
    check("p2_stall_wins", int'(pc), 66);
    run_n(1);
    check("p2_after_stall", int'(pc), 67);
    run_n(13);
    check("p2_pc80", int'(pc), 80);

    // Abort mid-RUN, restart with wrap-around select 0
    cyc(1, 1, 2, 0, 0, 0, 0);
    check("abort_running", int'(running), 0);
    check("abort_done", int'(done), 0);
    check("abort_pc", int'(pc), 80);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("p0_start", int'(pc), 0);
    check("p0_id", int'(prog_id), 0);

    // Program 3 near top of address space: wrap on step and branch
    cyc(1, 1, 3, 0, 0, 0, 0);
    cyc(1, 0, 3, 0, 0, 0, 0);
    check("p3_start", int'(pc), 1020);
    run_n(3);
    check("p3_top", int'(pc), 1023);
    run_n(2);
    check("p3_wrap", int'(pc), 1);
    cyc(1, 0, 3, 0, 1, -3, 0);
    check("p3_branch_wrap", int'(pc), 1022);

    // halt beats branch, then reset from DONE
    cyc(1, 0, 3, 0, 1, 7, 1);
    check("halt_wins_pc", int'(pc), 1022);
    check("halt_wins_done", int'(done), 1);
    cyc(0, 0, 3, 0, 0, 0, 0);
    check("rst_done_pc", int'(pc), 0);
    check("rst_done_done", int'(done), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(63) != 0),
          ($urandom_range(9) == 0),
          int'($urandom_range(3)),
          ($urandom_range(3) == 0),
          ($urandom_range(3) == 0),
          int'($urandom_range(255)),
          ($urandom_range(39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
